// File: rtl/conv_pkg.sv
// Shared constants and FSM state type for the convolution read-side front end.
package conv_pkg;
  localparam int IMG_W     = 8;
  localparam int IMG_H     = 8;
  localparam int K         = 3;
  localparam int DW        = 8;
  localparam int AW        = 6;
  localparam int OUT_W     = IMG_W - K + 1;
  localparam int CW        = 3;  // width of pixel / window coordinates
  localparam int DRAIN_LEN = 2;  // cycles to flush the RAM latency and window register

  typedef enum logic [1:0] {IDLE, FETCH, DRAIN} state_t;
endpackage

// File: rtl/conv_window_fetch_if.sv
// RAM read bus plus window output bus of the window fetcher.
interface conv_window_fetch_if;
  import conv_pkg::*;

  logic [AW-1:0]     ram_addr;
  logic [DW-1:0]     ram_dout;
  logic              win_valid;
  logic [K*K*DW-1:0] win_data;
  logic [CW-1:0]     win_row;
  logic [CW-1:0]     win_col;

  modport master (
    output ram_addr,
    input  ram_dout,
    output win_valid,
    output win_data,
    output win_row,
    output win_col
  );

  modport slave (
    input  ram_addr,
    output ram_dout,
    input  win_valid,
    input  win_data,
    input  win_row,
    input  win_col
  );
endinterface

// File: rtl/conv_line_buffer.sv
// One image row of pixels: registered write, asynchronous read by column.
module conv_line_buffer #(
  parameter int DEPTH = 8,
  parameter int DW    = 8,
  parameter int IW    = 3
) (
  input  logic          clk,
  input  logic          we,
  input  logic [IW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic [IW-1:0] raddr,
  output logic [DW-1:0] rdata
);
  logic [DW-1:0] mem [DEPTH];

  // Row storage; contents survive across frames and are never cleared.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];
endmodule

// File: rtl/conv_window_fetch.sv
// Raster-order image RAM walker that assembles 3x3 pixel windows for the
// convolution datapath, one window per cycle once two rows are buffered.
module conv_window_fetch #(
  parameter int IMG_W = conv_pkg::IMG_W,
  parameter int IMG_H = conv_pkg::IMG_H,
  parameter int K     = conv_pkg::K,
  parameter int DW    = conv_pkg::DW,
  parameter int AW    = conv_pkg::AW
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_st,
  conv_window_fetch_if.master bus,
  output logic                busy,
  output logic                out_st
);
  import conv_pkg::*;

  localparam int                NPIX      = IMG_W * IMG_H;
  localparam int                WW        = K * K * DW;
  localparam logic [AW-1:0]     LAST_ADDR = AW'(NPIX - 1);
  localparam logic [AW-1:0]     LAST_DRN  = AW'(DRAIN_LEN - 1);
  localparam logic [CW-1:0]     COL_LAST  = CW'(IMG_W - 1);
  localparam logic [CW-1:0]     ROW_LAST  = CW'(IMG_H - 1);
  localparam logic [CW-1:0]     EDGE      = CW'(K - 1);

  state_t        state, state_nxt;
  logic [AW-1:0] cnt, cnt_nxt;
  logic          done_nxt;

  logic          vld_p1;
  logic [CW-1:0] col_p1, row_p1;
  logic [DW-1:0] pix_p1, lb0_rd, lb1_rd;
  logic          win_hit;
  logic [WW-1:0] win_nxt;

  logic          vld_p2;
  logic [WW-1:0] win_p2;
  logic [CW-1:0] row_p2, col_p2;

  // FSM state, shared address/drain counter and registered done pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      cnt    <= '0;
      out_st <= 1'b0;
    end else begin
      state  <= state_nxt;
      cnt    <= cnt_nxt;
      out_st <= done_nxt;
    end
  end

  // Next state: one address per FETCH cycle, then a fixed-length drain.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    done_nxt  = 1'b0;
    case (state)
      IDLE: begin
        if (in_st) begin
          state_nxt = FETCH;
          cnt_nxt   = '0;
        end
      end
      FETCH: begin
        if (cnt == LAST_ADDR) begin
          state_nxt = DRAIN;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      DRAIN: begin
        if (cnt == LAST_DRN) begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
          done_nxt  = 1'b1;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

  // ---- stage p0: address issue ----
  assign bus.ram_addr = (state == FETCH) ? cnt : '0;
  assign busy         = (state != IDLE);

  // ---- stage p1: RAM data returns; pixel coordinates track it ----
  assign pix_p1 = bus.ram_dout;

  // Pixel coordinate counter, one cycle behind the address; wraps to 0 at frame end.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p1 <= 1'b0;
      col_p1 <= '0;
      row_p1 <= '0;
    end else begin
      vld_p1 <= (state == FETCH);
      if (vld_p1) begin
        if (col_p1 == COL_LAST) begin
          col_p1 <= '0;
          row_p1 <= (row_p1 == ROW_LAST) ? '0 : row_p1 + 1'b1;
        end else begin
          col_p1 <= col_p1 + 1'b1;
        end
      end
    end
  end

  conv_line_buffer #(.DEPTH(IMG_W), .DW(DW), .IW(CW)) lb0 (
    .clk   (clk),
    .we    (vld_p1),
    .waddr (col_p1),
    .wdata (pix_p1),
    .raddr (col_p1),
    .rdata (lb0_rd)
  );

  conv_line_buffer #(.DEPTH(IMG_W), .DW(DW), .IW(CW)) lb1 (
    .clk   (clk),
    .we    (vld_p1),
    .waddr (col_p1),
    .wdata (lb0_rd),
    .raddr (col_p1),
    .rdata (lb1_rd)
  );

  // Window shifted left one column with {lb1, lb0, pixel} as the new right column.
  always_comb begin
    win_nxt = win_p2;
    for (int r = 0; r < K; r++) begin
      for (int c = 0; c < K - 1; c++) begin
        win_nxt[(r*K + c)*DW +: DW] = win_p2[(r*K + c + 1)*DW +: DW];
      end
    end
    win_nxt[(K - 1)*DW +: DW]         = lb1_rd;
    win_nxt[(2*K - 1)*DW +: DW]       = lb0_rd;
    win_nxt[(K*K - 1)*DW +: DW]       = pix_p1;
  end

  assign win_hit = vld_p1 && (row_p1 >= EDGE) && (col_p1 >= EDGE);

  // ---- stage p2: registered window and its top-left coordinate ----
  // Window register shifts on every returned pixel; valid only once fully populated.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p2 <= 1'b0;
      win_p2 <= '0;
      row_p2 <= '0;
      col_p2 <= '0;
    end else begin
      vld_p2 <= win_hit;
      if (vld_p1) win_p2 <= win_nxt;
      if (win_hit) begin
        row_p2 <= row_p1 - EDGE;
        col_p2 <= col_p1 - EDGE;
      end
    end
  end

  assign bus.win_valid = vld_p2;
  assign bus.win_data  = win_p2;
  assign bus.win_row   = row_p2;
  assign bus.win_col   = col_p2;
endmodule

// File: doc/conv_window_fetch.md
# conv_window_fetch

Read-side front end for the 2D convolution datapath. On a start pulse it walks the 8x8 image RAM in raster order, one address per cycle. It buffers two previous rows in line buffers and emits each complete 3x3 pixel window as a registered 72-bit word with a valid strobe. Window order matches the 6x6 result ordering, row-major, so output index `n = win_row*6 + win_col` lines up with the convolution result index.

## Interface
Parameters:
- `IMG_W`, 8, image width in pixels
- `IMG_H`, 8, image height in pixels
- `K`, 3, kernel and window edge
- `DW`, 8, pixel width
- `AW`, 6, RAM address width (`IMG_W*IMG_H <= 2**AW`)

Ports:
- `clk`  in  1  single clock; all logic on the rising edge
- `rst`  in  1  reset, synchronous, active-high
- `in_st`  in  1  start request; sampled only in IDLE
- `ram_addr`  out  AW  read address to the image RAM
- `ram_dout`  in  DW  RAM read data; valid one cycle after `ram_addr`
- `win_valid`  out  1  `win_data`/`win_row`/`win_col` valid this cycle
- `win_data`  out  K*K*DW  window; element (r,c) at bits `[(r*K+c)*DW +: DW]`, r=0 is the top (oldest) row
- `win_row`, `win_col`  out  3 each  top-left coordinate of the window, 0..IMG_W-K
- `busy`  out  1  high from the first FETCH cycle through the last DRAIN cycle
- `out_st`  out  1  one-cycle done pulse

## Operation
- FSM states:
  - IDLE: `in_st=1` goes to FETCH.
  - FETCH: lasts exactly IMG_W*IMG_H cycles, then goes to DRAIN.
  - DRAIN: lasts 2 cycles, then goes to IDLE and asserts `out_st` in the first IDLE cycle.
- FETCH:
  - Issues `ram_addr` = 0, 1, … 63, one per cycle, with no gaps.
  - A pixel counter (col 0..IMG_W-1, row 0..IMG_H-1) follows the returning data one cycle behind. Col wraps 7→0 and row increments on the wrap.
- Each returned pixel at (r,c):
  - Window shifts left one column. The new right column is {lb1[c], lb0[c], pixel}, top to bottom.
  - Then lb1[c] ← lb0[c] and lb0[c] ← pixel.
- `win_valid` asserts for the pixel at (r,c) only when r ≥ K-1 and c ≥ K-1. In that case win_row=r-2 and win_col=c-2.
- Exactly 36 windows per frame, in groups of 6 per row, with 2 idle cycles between groups (the columns 0..1 refill).
- No backpressure: the consumer must take every valid window.
- Line buffers are not cleared between frames. Stale contents are never exposed because windows only emit from row 2 onward.
- `in_st` outside IDLE is ignored, including during DRAIN. `in_st` in the IDLE cycle that carries `out_st` is accepted.
- Reset values: `ram_addr`=0, `win_valid`=0, `win_data`=0, `win_row`=0, `win_col`=0, `busy`=0, `out_st`=0, state IDLE, counters 0.
- `rst` mid-frame:
  - Aborts on the next edge and returns to the reset values.
  - No `out_st` is produced for the aborted frame.
  - The next `in_st` restarts at address 0.
- `ram_addr` holds 0 in IDLE and DRAIN.

## Timing
- `in_st` is sampled high at edge E. The first FETCH cycle is t0 = E+1, with `ram_addr`=0 and `busy`=1.
- Address p is presented in cycle t0+p. Its data arrives in cycle t0+p+1. The window containing it as the bottom-right pixel is presented in cycle t0+p+2.
- First window (p=18) appears at t0+20. Last window (p=63) appears at t0+65.
- DRAIN occupies t0+64 and t0+65.
- In cycle t0+66: `out_st`=1 and `busy`=0.
- Start-to-start minimum is 67 cycles.

## Structure
- Shared package `conv_pkg` holds:
  - IMG_W, IMG_H, K, DW, AW.
  - OUT_W = IMG_W-K+1.
  - The FSM state enum (IDLE, FETCH, DRAIN).
- One sub-module `conv_line_buffer`:
  - Depth IMG_W, width DW, registered write, asynchronous read by column index.
  - Instantiated twice (lb0, lb1).
- Window register, counters and FSM live in the top module.

## Test plan
- RAM[a]=a, pulse `in_st`:
  - Window 0 at t0+20 = {0,1,2,8,9,10,16,17,18}, row 0, col 0.
  - Window 35 at t0+65 = {45,46,47,53,54,55,61,62,63}, row 5, col 5.
  - `out_st` at t0+66.
- Same frame:
  - Count exactly 36 `win_valid` cycles.
  - Pattern is 6 on, 2 off per row.
  - `win_row`/`win_col` run 0..5 row-major.
  - `busy` is high for exactly 66 cycles.
- `in_st` held high for 100 cycles:
  - Second frame's first address (0) is issued at t0+67.
  - Extra `in_st` during FETCH/DRAIN has no effect.
- Back-to-back with RAM rewritten to 255-a between frames:
  - Frame 2 window 0 = {255,254,253,247,246,245,239,238,237}.
  - No frame-1 data leaks into frame 2.
- `rst` at t0+30:
  - All outputs are 0 on the next cycle.
  - No `out_st`.
  - A fresh `in_st` yields a correct window 0 at its own t0+20.
- Pixel 0xFF everywhere: every window equals all-ones and stays full 72-bit width, with no truncation.
